// File: rtl/usr_pkg.sv
// usr_pkg
// Shared definitions for the universal shift register:
//   usr_mode_t    - 3-bit operation select, encoded as on the Mode port
//   usr_cnt_width - width of the shift counter (counts 0..WIDTH inclusive)
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } usr_mode_t;

    // The counter must hold WIDTH itself, hence WIDTH+1 distinct values.
    function automatic int usr_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell
// One storage bit of the universal shift register: an 8:1 next-value mux
// followed by a flop with synchronous active-high reset and clock enable.
// The neighbouring bit values for each shift/rotate flavour are wired up by
// the parent, so the cell itself is position-independent.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high; loads RST_BIT
//   en       clock enable; when 0 the bit holds
//   mode     operation select
//   d        parallel load bit
//   shl_src  value this bit takes on a logical left shift
//   shr_src  value this bit takes on a logical right shift
//   rol_src  value this bit takes on a rotate left
//   ror_src  value this bit takes on a rotate right
//   asr_src  value this bit takes on an arithmetic right shift
//   q        stored bit
//   nxt      value q would take on the next enabled edge (for parity look-ahead)
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  usr_mode_t mode,
    input  logic      d,
    input  logic      shl_src,
    input  logic      shr_src,
    input  logic      rol_src,
    input  logic      ror_src,
    input  logic      asr_src,
    output logic      q,
    output logic      nxt
);

    always_comb begin
        nxt = q;
        unique case (mode)
            MODE_HOLD: nxt = q;
            MODE_LOAD: nxt = d;
            MODE_SHL:  nxt = shl_src;
            MODE_SHR:  nxt = shr_src;
            MODE_ROL:  nxt = rol_src;
            MODE_ROR:  nxt = ror_src;
            MODE_ASR:  nxt = asr_src;
            MODE_CLR:  nxt = 1'b0;
            default:   nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_BIT;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// WIDTH-bit universal shift register with hold, load, logical shifts,
// rotates, arithmetic right shift and clear, plus a saturating counter of
// shift/rotate operations since the last LOAD/CLR/reset.
// Optional feature macro: USR_PARITY_EN adds a registered parity output Par.
// Ports:
//   Clk     rising-edge clock
//   R       synchronous reset, active-high; priority over En and Mode
//   En      clock enable; when 0 all state holds
//   Mode    operation select (usr_mode_t encoding)
//   D       parallel load data
//   Sin_L   serial input for SHL, enters bit 0
//   Sin_R   serial input for SHR, enters bit WIDTH-1
//   Q       register contents
//   Qn      bitwise complement of Q
//   Sout_L  Q[WIDTH-1]
//   Sout_R  Q[0]
//   Cnt     shift/rotate operations since last LOAD/CLR/reset, saturating at WIDTH
//   Done    registered; 1 exactly when Cnt == WIDTH
//   Par     (USR_PARITY_EN only) registered XOR-reduction of Q
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             Clk,
    input  logic                             R,
    input  logic                             En,
    input  logic [2:0]                       Mode,
    input  logic [WIDTH-1:0]                 D,
    input  logic                             Sin_L,
    input  logic                             Sin_R,
    output logic [WIDTH-1:0]                 Q,
    output logic [WIDTH-1:0]                 Qn,
    output logic                             Sout_L,
    output logic                             Sout_R,
    output logic [usr_cnt_width(WIDTH)-1:0]  Cnt,
    output logic                             Done
`ifdef USR_PARITY_EN
    ,
    output logic                             Par
`endif
);

    localparam int                CNT_W   = usr_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);

    usr_mode_t        mode;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] rol_vec;
    logic [WIDTH-1:0] ror_vec;
    logic [WIDTH-1:0] asr_vec;
    logic [WIDTH-1:0] q_nxt;
    logic             counted;

    assign mode = usr_mode_t'(Mode);

    // Candidate next words for each movement; bit i of each vector feeds cell i.
    assign shl_vec = {Q[WIDTH-2:0], Sin_L};
    assign shr_vec = {Sin_R, Q[WIDTH-1:1]};
    assign rol_vec = {Q[WIDTH-2:0], Q[WIDTH-1]};
    assign ror_vec = {Q[0], Q[WIDTH-1:1]};
    assign asr_vec = {Q[WIDTH-1], Q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_bit_cell #(
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .clk     (Clk),
            .rst     (R),
            .en      (En),
            .mode    (mode),
            .d       (D[i]),
            .shl_src (shl_vec[i]),
            .shr_src (shr_vec[i]),
            .rol_src (rol_vec[i]),
            .ror_src (ror_vec[i]),
            .asr_src (asr_vec[i]),
            .q       (Q[i]),
            .nxt     (q_nxt[i])
        );
    end

    assign Qn     = ~Q;
    assign Sout_L = Q[WIDTH-1];
    assign Sout_R = Q[0];

    // SHL, SHR, ROL, ROR and ASR advance the counter.
    always_comb begin
        counted = 1'b0;
        unique case (mode)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: counted = 1'b1;
            default:                                          counted = 1'b0;
        endcase
    end

    // Counter saturates at WIDTH; Done is set on the edge it reaches WIDTH
    // and stays set until LOAD, CLR or reset.
    always_ff @(posedge Clk) begin
        if (R) begin
            Cnt  <= '0;
            Done <= 1'b0;
        end else if (En) begin
            if (mode == MODE_LOAD || mode == MODE_CLR) begin
                Cnt  <= '0;
                Done <= 1'b0;
            end else if (counted && Cnt != CNT_MAX) begin
                Cnt <= Cnt + 1'b1;
                if (Cnt == CNT_MAX - 1'b1) begin
                    Done <= 1'b1;
                end
            end
        end
    end

`ifdef USR_PARITY_EN
    // Parity is taken from the next Q value so it updates on the same edge as Q.
    always_ff @(posedge Clk) begin
        if (R) begin
            Par <= ^RESET_VAL;
        end else if (En) begin
            Par <= ^q_nxt;
        end
    end
`else
    // Look-ahead word is only needed for parity.
    logic unused_nxt;
    assign unused_nxt = ^q_nxt;
`endif

endmodule
